// File: rtl/nmr_shift_reg_scrub_if.sv
// -----------------------------------------------------------------------------
// nmr_shift_reg_scrub_if
// Bus bundle for the N-modular-redundant scrubbing shift register.
//   master : functional controls, serial/parallel data in, fault-injection
//            strobe and error-clear; observes voted data and fault status.
//   slave  : the register itself.
// Signals:
//   enable, mode[1:0], load, serial_in, parallel_in[WIDTH]  functional inputs
//   inj_en, inj_sel[SEL_W], inj_mask[WIDTH]                 SEU injection
//   err_clr                                                 clear error stats
//   parallel_out[WIDTH], serial_out                         voted data
//   fault_vec[REPLICAS], fault_pulse, err_count[CNT_W],
//   replica_failed[REPLICAS]                                fault status
// -----------------------------------------------------------------------------
interface nmr_shift_reg_scrub_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned REPLICAS = 3,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned SEL_W = $clog2(REPLICAS);

    logic                enable;
    logic [1:0]          mode;
    logic                load;
    logic                serial_in;
    logic [WIDTH-1:0]    parallel_in;
    logic                inj_en;
    logic [SEL_W-1:0]    inj_sel;
    logic [WIDTH-1:0]    inj_mask;
    logic                err_clr;
    logic [WIDTH-1:0]    parallel_out;
    logic                serial_out;
    logic [REPLICAS-1:0] fault_vec;
    logic                fault_pulse;
    logic [CNT_W-1:0]    err_count;
    logic [REPLICAS-1:0] replica_failed;

    modport master (
        output enable, mode, load, serial_in, parallel_in,
        output inj_en, inj_sel, inj_mask, err_clr,
        input  parallel_out, serial_out, fault_vec, fault_pulse,
        input  err_count, replica_failed
    );

    modport slave (
        input  enable, mode, load, serial_in, parallel_in,
        input  inj_en, inj_sel, inj_mask, err_clr,
        output parallel_out, serial_out, fault_vec, fault_pulse,
        output err_count, replica_failed
    );
endinterface

// File: rtl/nmr_shift_reg_scrub.sv
// -----------------------------------------------------------------------------
// nmr_shift_reg_scrub
// N-modular-redundant universal shift register with continuous scrubbing.
// Every replica is rewritten each cycle from the bitwise majority vote, so a
// single upset lives for exactly one cycle. Mismatches are reported per
// replica, counted (saturating), and replicas that disagree for FAULT_THRESH
// consecutive cycles get a sticky failed flag (report-only).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   nmr_shift_reg_scrub_if.slave (controls, data, injection, status)
// Modes: 00 SISO right, 01 SISO left, 10 PISO (shift right, zero fill), 11 PIPO
// -----------------------------------------------------------------------------
module nmr_shift_reg_scrub #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned REPLICAS     = 3,
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_W        = 8
) (
    input logic                 clk,
    input logic                 rst,
    nmr_shift_reg_scrub_if.slave bus
);
    localparam int unsigned SEL_W  = $clog2(REPLICAS);
    localparam int unsigned VCNT_W = $clog2(REPLICAS + 1);
    localparam int unsigned CONS_W = $clog2(FAULT_THRESH + 1);
    localparam int unsigned MAJ    = REPLICAS / 2;

    logic [REPLICAS-1:0][WIDTH-1:0]  rep_q;
    logic [REPLICAS-1:0]             fault_vec_q;
    logic                            fault_pulse_q;
    logic [CNT_W-1:0]                err_count_q;
    logic [REPLICAS-1:0][CONS_W-1:0] cons_q;
    logic [REPLICAS-1:0]             failed_q;

    logic [WIDTH-1:0]    voted_c;
    logic [WIDTH-1:0]    next_c;
    logic [REPLICAS-1:0] mismatch_c;

    // Per-bit strict majority across all replicas.
    function automatic logic [WIDTH-1:0] majority(
        input logic [REPLICAS-1:0][WIDTH-1:0] r
    );
        logic [VCNT_W-1:0] ones;
        logic [WIDTH-1:0]  v;
        v = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            ones = '0;
            for (int k = 0; k < int'(REPLICAS); k++) begin
                ones = ones + VCNT_W'(r[k][b]);
            end
            v[b] = (ones > VCNT_W'(MAJ));
        end
        return v;
    endfunction

    // Vote and per-replica disagreement, straight from the flops.
    always_comb begin
        voted_c = majority(rep_q);
        for (int r = 0; r < int'(REPLICAS); r++) begin
            mismatch_c[r] = (rep_q[r] != voted_c);
        end
    end

    // Common next state; always derived from the vote, never a replica's own value.
    always_comb begin
        next_c = voted_c;
        if (bus.enable) begin
            case (bus.mode)
                2'b00: next_c = {bus.serial_in, voted_c[WIDTH-1:1]};
                2'b01: next_c = {voted_c[WIDTH-2:0], bus.serial_in};
                2'b10: next_c = bus.load ? bus.parallel_in : {1'b0, voted_c[WIDTH-1:1]};
                2'b11: next_c = bus.load ? bus.parallel_in : voted_c;
            endcase
        end
    end

    // Replica flops; an out-of-range inj_sel matches no replica and is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q <= '0;
        end else begin
            for (int r = 0; r < int'(REPLICAS); r++) begin
                rep_q[r] <= next_c ^ ((bus.inj_en && (bus.inj_sel == SEL_W'(r)))
                                      ? bus.inj_mask : '0);
            end
        end
    end

    // Fault reporting; unaffected by err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_vec_q   <= '0;
            fault_pulse_q <= 1'b0;
        end else begin
            fault_vec_q   <= mismatch_c;
            fault_pulse_q <= |mismatch_c;
        end
    end

    // Saturating corrected-error counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count_q <= '0;
        end else if (bus.err_clr) begin
            err_count_q <= '0;
        end else if ((|mismatch_c) && (err_count_q != '1)) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    // Consecutive-mismatch tracking and sticky failed flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cons_q   <= '0;
            failed_q <= '0;
        end else if (bus.err_clr) begin
            cons_q   <= '0;
            failed_q <= '0;
        end else begin
            for (int r = 0; r < int'(REPLICAS); r++) begin
                if (mismatch_c[r]) begin
                    if (cons_q[r] != CONS_W'(FAULT_THRESH)) begin
                        cons_q[r] <= cons_q[r] + CONS_W'(1);
                    end
                    // Flag on the edge where the count reaches the threshold.
                    if (cons_q[r] >= CONS_W'(FAULT_THRESH - 1)) begin
                        failed_q[r] <= 1'b1;
                    end
                end else begin
                    cons_q[r] <= '0;
                end
            end
        end
    end

    assign bus.parallel_out   = voted_c;
    assign bus.serial_out     = bus.mode[0] ? voted_c[WIDTH-1] : voted_c[0];
    assign bus.fault_vec      = fault_vec_q;
    assign bus.fault_pulse    = fault_pulse_q;
    assign bus.err_count      = err_count_q;
    assign bus.replica_failed = failed_q;
endmodule

// File: tb/tb_nmr_shift_reg_scrub.sv
// -----------------------------------------------------------------------------
// tb_nmr_shift_reg_scrub
// Self-checking bench. Three instances: default (16b, 3 replicas, 8b counter),
// a 2-bit counter variant and a 5-replica variant. Directed vector table plus
// randomized traffic against a behavioural model of the default instance.
// -----------------------------------------------------------------------------
module tb_nmr_shift_reg_scrub;
    localparam int unsigned THRESH = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nmr_shift_reg_scrub_if #(.WIDTH(16), .REPLICAS(3), .CNT_W(8)) ifa ();
    nmr_shift_reg_scrub_if #(.WIDTH(16), .REPLICAS(3), .CNT_W(2)) ifb ();
    nmr_shift_reg_scrub_if #(.WIDTH(16), .REPLICAS(5), .CNT_W(8)) ifc ();

    nmr_shift_reg_scrub #(.WIDTH(16), .REPLICAS(3), .FAULT_THRESH(4), .CNT_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    nmr_shift_reg_scrub #(.WIDTH(16), .REPLICAS(3), .FAULT_THRESH(4), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    nmr_shift_reg_scrub #(.WIDTH(16), .REPLICAS(5), .FAULT_THRESH(4), .CNT_W(8))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // ---------------- behavioural model of dut_a ----------------
    typedef struct packed {
        logic [2:0][15:0] rep;
        logic [2:0]       fv;
        logic             pulse;
        logic [7:0]       cnt;
        logic [2:0][2:0]  cons;
        logic [2:0]       failed;
    } mstate_t;

    mstate_t m;

    function automatic logic [15:0] vote3(input logic [2:0][15:0] r);
        logic [15:0] v;
        int ones;
        for (int b = 0; b < 16; b++) begin
            ones = 0;
            for (int k = 0; k < 3; k++) ones += int'(r[k][b]);
            v[b] = (2 * ones > 3);
        end
        return v;
    endfunction

    function automatic mstate_t model_next(
        input mstate_t s, input logic en, input logic [1:0] mode,
        input logic load, input logic sin, input logic [15:0] pin,
        input logic inj, input logic [1:0] sel, input logic [15:0] mask,
        input logic clr
    );
        mstate_t     n;
        logic [15:0] base, nxt;
        logic [2:0]  mis;
        n = s;
        base = vote3(s.rep);
        for (int r = 0; r < 3; r++) mis[r] = (s.rep[r] != base);
        nxt = base;
        if (en) begin
            case (mode)
                2'd0: nxt = (base >> 1) | (16'(sin) << 15);
                2'd1: nxt = (base << 1) | 16'(sin);
                2'd2: nxt = load ? pin : (base >> 1);
                default: nxt = load ? pin : base;
            endcase
        end
        for (int r = 0; r < 3; r++)
            n.rep[r] = nxt ^ ((inj && int'(sel) == r) ? mask : 16'h0);
        n.fv    = mis;
        n.pulse = |mis;
        if (clr) begin
            n.cnt = 8'd0; n.cons = '0; n.failed = '0;
        end else begin
            if (|mis && s.cnt != 8'hFF) n.cnt = s.cnt + 8'd1;
            for (int r = 0; r < 3; r++) begin
                if (mis[r]) begin
                    if (s.cons[r] < 3'(THRESH)) n.cons[r] = s.cons[r] + 3'd1;
                    if (n.cons[r] == 3'(THRESH)) n.failed[r] = 1'b1;
                end else begin
                    n.cons[r] = 3'd0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else m <= model_next(m, ifa.enable, ifa.mode, ifa.load, ifa.serial_in,
                             ifa.parallel_in, ifa.inj_en, ifa.inj_sel,
                             ifa.inj_mask, ifa.err_clr);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic en; logic [1:0] mode; logic load; logic sin; logic [15:0] pin;
        logic inj; logic [1:0] sel; logic [15:0] mask; logic clr;
        logic [15:0] e_out; logic e_so; logic [2:0] e_fv; logic [7:0] e_cnt;
        logic [2:0] e_failed;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic en, input logic [1:0] mode, input logic load, input logic sin,
        input logic [15:0] pin, input logic inj, input logic [1:0] sel,
        input logic [15:0] mask, input logic clr, input logic [15:0] e_out,
        input logic e_so, input logic [2:0] e_fv, input logic [7:0] e_cnt,
        input logic [2:0] e_failed
    );
        vec_t v;
        v.en = en; v.mode = mode; v.load = load; v.sin = sin; v.pin = pin;
        v.inj = inj; v.sel = sel; v.mask = mask; v.clr = clr; v.e_out = e_out;
        v.e_so = e_so; v.e_fv = e_fv; v.e_cnt = e_cnt; v.e_failed = e_failed;
        tbl.push_back(v);
    endfunction

    task automatic check_zero_a(input string tag);
        chk({tag, "_out"},    32'(ifa.parallel_out),   32'h0);
        chk({tag, "_so"},     32'(ifa.serial_out),     32'h0);
        chk({tag, "_fv"},     32'(ifa.fault_vec),      32'h0);
        chk({tag, "_pulse"},  32'(ifa.fault_pulse),    32'h0);
        chk({tag, "_cnt"},    32'(ifa.err_count),      32'h0);
        chk({tag, "_failed"}, 32'(ifa.replica_failed), 32'h0);
    endtask

    task automatic rand_a(input int n);
        logic [15:0] e_out;
        for (int i = 0; i < n; i++) begin
            ifa.enable      = ($urandom_range(3) != 0);
            ifa.mode        = 2'($urandom_range(3));
            ifa.load        = ($urandom_range(3) == 0);
            ifa.serial_in   = 1'($urandom_range(1));
            ifa.parallel_in = 16'($urandom);
            ifa.inj_en      = ($urandom_range(2) == 0);
            if ($urandom_range(9) == 0) ifa.inj_sel = 2'($urandom_range(3));
            ifa.inj_mask    = 16'($urandom);
            ifa.err_clr     = ($urandom_range(19) == 0);
            tick();
            e_out = vote3(m.rep);
            chk("rnd_out",    32'(ifa.parallel_out),   32'(e_out));
            chk("rnd_so",     32'(ifa.serial_out),     32'(ifa.mode[0] ? e_out[15] : e_out[0]));
            chk("rnd_fv",     32'(ifa.fault_vec),      32'(m.fv));
            chk("rnd_pulse",  32'(ifa.fault_pulse),    32'(m.pulse));
            chk("rnd_cnt",    32'(ifa.err_count),      32'(m.cnt));
            chk("rnd_failed", 32'(ifa.replica_failed), 32'(m.failed));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        ifa.enable = 0; ifa.mode = 0; ifa.load = 0; ifa.serial_in = 0; ifa.parallel_in = 0;
        ifa.inj_en = 0; ifa.inj_sel = 0; ifa.inj_mask = 0; ifa.err_clr = 0;
        ifb.enable = 0; ifb.mode = 0; ifb.load = 0; ifb.serial_in = 0; ifb.parallel_in = 0;
        ifb.inj_en = 0; ifb.inj_sel = 0; ifb.inj_mask = 0; ifb.err_clr = 0;
        ifc.enable = 0; ifc.mode = 0; ifc.load = 0; ifc.serial_in = 0; ifc.parallel_in = 0;
        ifc.inj_en = 0; ifc.inj_sel = 0; ifc.inj_mask = 0; ifc.err_clr = 0;

        //   en mode ld sin pin      inj sel mask     clr  out      so fv    cnt failed
        add(1, 3, 1, 0, 16'hA5C3, 0, 0, 16'h0000, 0, 16'hA5C3, 1, 3'b000, 0, 3'b000);
        add(0, 3, 0, 0, 16'h0000, 1, 1, 16'h00FF, 0, 16'hA5C3, 1, 3'b000, 0, 3'b000);
        add(0, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hA5C3, 1, 3'b010, 1, 3'b000);
        add(0, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hA5C3, 1, 3'b000, 1, 3'b000);
        add(1, 3, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 3'b000, 1, 3'b000);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h8000, 0, 3'b000, 1, 3'b000);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'hC000, 0, 3'b000, 1, 3'b000);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'hE000, 0, 3'b000, 1, 3'b000);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'hF000, 0, 3'b000, 1, 3'b000);
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hE000, 1, 3'b000, 1, 3'b000);
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hC000, 1, 3'b000, 1, 3'b000);
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h8000, 1, 3'b000, 1, 3'b000);
        add(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 3'b000, 1, 3'b000);
        add(1, 3, 1, 0, 16'h1234, 0, 0, 16'h0000, 1, 16'h1234, 0, 3'b000, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 1, 2, 16'h0001, 0, 16'h1234, 0, 3'b000, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 1, 2, 16'h0001, 0, 16'h1234, 0, 3'b100, 1, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 1, 2, 16'h0001, 0, 16'h1234, 0, 3'b100, 2, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 1, 2, 16'h0001, 0, 16'h1234, 0, 3'b100, 3, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 0, 3'b100, 4, 3'b100);
        add(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 0, 3'b000, 4, 3'b100);
        add(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234, 0, 3'b000, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 1, 3, 16'hFFFF, 0, 16'h1234, 0, 3'b000, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h1234, 0, 3'b000, 0, 3'b000);
        add(1, 2, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h091A, 0, 3'b000, 0, 3'b000);
        add(1, 2, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h048D, 1, 3'b000, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 1, 0, 16'h0F00, 0, 16'h048D, 0, 3'b000, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h048D, 0, 3'b001, 0, 3'b000);
        add(1, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h048D, 0, 3'b000, 0, 3'b000);
        add(0, 3, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 0, 16'h048D, 0, 3'b000, 0, 3'b000);

        repeat (2) @(posedge clk);
        #1;
        check_zero_a("reset");
        chk("reset_b_out", 32'(ifb.parallel_out), 32'h0);
        chk("reset_c_fv",  32'(ifc.fault_vec),    32'h0);
        rst = 1'b1;

        // Directed table on dut_a.
        foreach (tbl[i]) begin
            ifa.enable = tbl[i].en;   ifa.mode = tbl[i].mode;   ifa.load = tbl[i].load;
            ifa.serial_in = tbl[i].sin; ifa.parallel_in = tbl[i].pin;
            ifa.inj_en = tbl[i].inj;  ifa.inj_sel = tbl[i].sel; ifa.inj_mask = tbl[i].mask;
            ifa.err_clr = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_out", i),    32'(ifa.parallel_out),   32'(tbl[i].e_out));
            chk($sformatf("vec%0d_so", i),     32'(ifa.serial_out),     32'(tbl[i].e_so));
            chk($sformatf("vec%0d_fv", i),     32'(ifa.fault_vec),      32'(tbl[i].e_fv));
            chk($sformatf("vec%0d_pulse", i),  32'(ifa.fault_pulse),    32'(|tbl[i].e_fv));
            chk($sformatf("vec%0d_cnt", i),    32'(ifa.err_count),      32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_failed", i), 32'(ifa.replica_failed), 32'(tbl[i].e_failed));
        end

        // Randomized traffic against the model, with a mid-run reset.
        rand_a(250);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero_a("midrst");
        @(negedge clk);
        rst = 1'b1;
        rand_a(250);
        ifa.inj_en = 0; ifa.err_clr = 0; ifa.enable = 0;

        // 2-bit counter saturation with isolated injections.
        ifb.enable = 1; ifb.mode = 2'd3; ifb.load = 1; ifb.parallel_in = 16'h5555;
        tick();
        chk("b_load", 32'(ifb.parallel_out), 32'h5555);
        ifb.enable = 0; ifb.load = 0;
        for (int k = 0; k < 5; k++) begin
            ifb.inj_en = 1; ifb.inj_sel = 2'(k % 3); ifb.inj_mask = 16'h0010;
            tick();
            ifb.inj_en = 0;
            tick();
            chk($sformatf("b_fv%0d", k),  32'(ifb.fault_vec), 32'(3'b001 << (k % 3)));
            chk($sformatf("b_cnt%0d", k), 32'(ifb.err_count), 32'((k + 1 < 3) ? k + 1 : 3));
            tick();
            chk($sformatf("b_out%0d", k), 32'(ifb.parallel_out), 32'h5555);
        end
        chk("b_failed", 32'(ifb.replica_failed), 32'h0);

        // 5-replica instance.
        ifc.enable = 1; ifc.mode = 2'd3; ifc.load = 1; ifc.parallel_in = 16'hC3A5;
        tick();
        chk("c_load", 32'(ifc.parallel_out), 32'hC3A5);
        ifc.load = 0;
        ifc.inj_en = 1; ifc.inj_sel = 3'd0; ifc.inj_mask = 16'h8000;
        tick();
        chk("c_out0", 32'(ifc.parallel_out), 32'hC3A5);
        chk("c_fv0",  32'(ifc.fault_vec),    32'h0);
        ifc.inj_sel = 3'd3;
        tick();
        chk("c_out1", 32'(ifc.parallel_out), 32'hC3A5);
        chk("c_fv1",  32'(ifc.fault_vec),    32'(5'b00001));
        ifc.inj_en = 0;
        tick();
        chk("c_fv2",  32'(ifc.fault_vec),    32'(5'b01000));
        chk("c_cnt2", 32'(ifc.err_count),    32'd2);
        tick();
        chk("c_fv3",   32'(ifc.fault_vec),   32'h0);
        chk("c_pulse3", 32'(ifc.fault_pulse), 32'h0);
        ifc.inj_en = 1; ifc.inj_sel = 3'd7; ifc.inj_mask = 16'hFFFF;
        tick();
        ifc.inj_en = 0;
        tick();
        chk("c_sel7_fv",  32'(ifc.fault_vec),    32'h0);
        chk("c_sel7_out", 32'(ifc.parallel_out), 32'hC3A5);
        ifc.inj_en = 1; ifc.inj_sel = 3'd4; ifc.inj_mask = 16'h0001;
        tick();
        ifc.inj_en = 0;
        tick();
        chk("c_sel4_fv",  32'(ifc.fault_vec),    32'(5'b10000));
        chk("c_sel4_cnt", 32'(ifc.err_count),    32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
